muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Iterative RV32M multiply/divide unit with its own sequencing FSM; sits in the EX stage beside the ALU of the 5-stage core.
- Selected by the decoder for OPCODE_RTYPE with funct7 = 0000001; op is funct3.
- Holds the pipeline via stall until the result is ready, then presents the result for one cycle.
- Radix-2: one bit per cycle; divide-by-zero and signed overflow take a 1-cycle fast path.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- start  input  1  EX holds an M-extension instruction; level, held while stall is high
- op  input  3  funct3: MUL 000, MULH 001, MULHSU 010, MULHU 011, DIV 100, DIVU 101, REM 110, REMU 111
- src_a  input  XLEN  rs1 value (forwarded)
- src_b  input  XLEN  rs2 value (forwarded)
- kill  input  1  EX flush (branch mispredict or trap); aborts the operation
- stall  output  1  combinational; holds IF/ID/EX while the operation is in flight
- busy  output  1  registered; high in ITER and FIX
- result_valid  output  1  registered; one-cycle pulse in DONE
- result  output  XLEN  registered; valid only when result_valid is high

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: state IDLE, busy 0, result_valid 0, result 0, internal accumulators 0.
- stall is forced 0 while reset is high.
- States:
  - IDLE:
    - On start, latch op and operand signs, take magnitudes per signedness, check special cases.
    - If special, go to DONE; else go to ITER with count = 0.
  - ITER: one shift-add (multiply) or shift-compare-subtract (divide) step per cycle; count increments; go to FIX when count = XLEN-1.
  - FIX: negate the 2*XLEN product or the quotient/remainder as required; select the output half; register result; go to DONE.
  - DONE: result_valid = 1; go to IDLE unconditionally; start is ignored in DONE.
- Latency:
  - Normal path: start sampled in IDLE at edge 0; ITER occupies cycles 1..32; FIX is cycle 33; result_valid is high in cycle 34.
  - Fast path: result_valid is high in cycle 1.
- stall = (state==IDLE & start & !kill) | state==ITER | state==FIX.
  - stall is low in DONE, so EX advances and captures result in the same cycle.
  - The next start is accepted in the following IDLE cycle.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: src_a signed, src_b unsigned.
  - MULHU, DIVU, REMU: both unsigned.
- Result selection:
  - MUL returns product[31:0]; MULH, MULHSU, MULHU return product[63:32].
  - Quotient sign = sign_a XOR sign_b; remainder takes the sign of the dividend.
- Special cases (fast path, no iteration):
  - src_b == 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return src_a.
  - DIV/REM with src_a == 0x80000000 and src_b == 0xFFFFFFFF: DIV returns 0x80000000; REM returns 0.
  - Multiplies never use the fast path.
- Abort:
  - kill (any state) or reset: state becomes IDLE next edge, busy 0, result_valid 0; no partial result is ever signalled.
  - kill has priority over start in the same cycle.
- start dropping mid-operation (not via kill) is ignored; the operation completes.
- Width: product accumulator is 2*XLEN bits; divider remainder is XLEN+1 bits for the subtract compare; count is clog2(XLEN) bits.

Decomposition:
- Shared header muldiv_op.vh:
  - MULDIV_* funct3 defines (MUL..REMU).
  - MULDIV_FUNCT7 = 7'b0000001.
  - FSM state encodings MD_IDLE, MD_ITER, MD_FIX, MD_DONE.
- Sub-module muldiv_iter_datapath:
  - Holds the accumulator/remainder/quotient registers and performs one step per enable.
  - Control inputs: load, step, is_div.
- muldiv_sequencer owns the FSM, counter, sign bookkeeping, special-case detection and FIX/result muxing.

Test Plan:
- MUL 0x00000007 × 0xFFFFFFFD -> result 0xFFFFFFEB; stall high cycles 0..33; result_valid only in cycle 34; busy high cycles 1..33.
- src_a = src_b = 0xFFFFFFFF -> MULHU 0xFFFFFFFE, MULH 0x00000000, MULHSU 0xFFFFFFFF, MUL 0x00000001.
- DIV 0xFFFFFFF9 / 0x00000002 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU -> 0x7FFFFFFC; REMU -> 0x00000001.
- Fast path:
  - DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 0x00000005; REMU 5/0 -> 0x00000005.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
  - In all fast-path cases result_valid is in cycle 1 and stall is high only in cycle 0.
- kill in ITER cycle 10 -> IDLE at the next edge, no result_valid pulse; an immediate new DIVU 100/7 returns 14 at cycle 34 of the new op.
- Same abort check using reset instead of kill.
- Back-to-back: MUL then DIV with start re-asserted the cycle after DONE -> both results correct, one result_valid pulse each, no missed start.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// rtl/muldiv_sequencer_pkg.sv - RV32M funct3 codes, FSM states and signedness helpers
package muldiv_sequencer_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_ITER = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    function automatic logic src_a_signed(input logic [2:0] op);
        return !(op == OP_MULHU || op == OP_DIVU || op == OP_REMU);
    endfunction

    function automatic logic src_b_signed(input logic [2:0] op);
        return (op == OP_MUL || op == OP_MULH || op == OP_DIV || op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// rtl/muldiv_sequencer_if.sv - EX-stage request/response bundle for the mul/div unit
interface muldiv_sequencer_if #(parameter int XLEN = 32);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            kill;
    logic            stall;
    logic            busy;
    logic            result_valid;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, src_a, src_b, kill,
        input  stall, busy, result_valid, result
    );

    modport slave (
        input  start, op, src_a, src_b, kill,
        output stall, busy, result_valid, result
    );
endinterface

// File: rtl/muldiv_sequencer_iter_datapath.sv
// rtl/muldiv_sequencer_iter_datapath.sv - radix-2 shift-add / restoring-divide step engine
module muldiv_sequencer_iter_datapath #(parameter int XLEN = 32) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_step,
    input  logic              i_is_div,
    input  logic [XLEN-1:0]   i_opnd_a,
    input  logic [XLEN-1:0]   i_opnd_b,
    output logic [2*XLEN-1:0] o_product,
    output logic [XLEN-1:0]   o_quotient,
    output logic [XLEN-1:0]   o_remainder
);
    // r_acc low half holds the multiplier (multiply) or dividend/quotient (divide)
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_opnd_b;

    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_div_shift;
    logic [XLEN:0]     w_div_diff;
    logic              w_div_ge;

    assign w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd_b} : '0);
    assign w_div_shift = {r_rem, r_acc[XLEN-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opnd_b};
    assign w_div_ge    = !w_div_diff[XLEN];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc    <= '0;
            r_rem    <= '0;
            r_opnd_b <= '0;
        end else if (i_load) begin
            r_acc    <= {{XLEN{1'b0}}, i_opnd_a};
            r_rem    <= '0;
            r_opnd_b <= i_opnd_b;
        end else if (i_step) begin
            if (i_is_div) begin
                r_acc[XLEN-1:0] <= {r_acc[XLEN-2:0], w_div_ge};
                r_rem           <= w_div_ge ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0];
            end else begin
                r_acc <= {w_mul_sum, r_acc[XLEN-1:1]};
            end
        end
    end

    assign o_product   = r_acc;
    assign o_quotient  = r_acc[XLEN-1:0];
    assign o_remainder = r_rem;
endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative RV32M multiply/divide unit with pipeline stall FSM
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(parameter int XLEN = 32) (
    input  logic             clk,
    input  logic             reset,
    muldiv_sequencer_if.slave bus
);
    localparam int              CNT_W   = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         r_state, w_next_state;
    logic [2:0]        r_op;
    logic              r_sign_a, r_sign_b;
    logic [CNT_W-1:0]  r_count;
    logic [XLEN-1:0]   r_result;
    logic              r_busy, r_result_valid;

    logic              w_sign_a, w_sign_b, w_accept, w_special, w_load, w_step, w_last;
    logic [XLEN-1:0]   w_mag_a, w_mag_b, w_special_result, w_fix_result;
    logic [XLEN-1:0]   w_quotient, w_remainder, w_quot_fix, w_rem_fix;
    logic [2*XLEN-1:0] w_product, w_prod_fix;

    assign w_sign_a = src_a_signed(bus.op) & bus.src_a[XLEN-1];
    assign w_sign_b = src_b_signed(bus.op) & bus.src_b[XLEN-1];
    assign w_mag_a  = w_sign_a ? (~bus.src_a + 1'b1) : bus.src_a;
    assign w_mag_b  = w_sign_b ? (~bus.src_b + 1'b1) : bus.src_b;

    // op[1] separates REM* from DIV*, op[0] clear marks the signed variants
    always_comb begin
        w_special        = 1'b0;
        w_special_result = '0;
        if (bus.op[2]) begin
            if (bus.src_b == '0) begin
                w_special        = 1'b1;
                w_special_result = bus.op[1] ? bus.src_a : '1;
            end else if (!bus.op[0] && bus.src_a == INT_MIN && bus.src_b == '1) begin
                w_special        = 1'b1;
                w_special_result = bus.op[1] ? '0 : INT_MIN;
            end
        end
    end

    assign w_accept = (r_state == MD_IDLE) && bus.start && !bus.kill;
    assign w_load   = w_accept && !w_special;
    assign w_step   = (r_state == MD_ITER) && !bus.kill;
    assign w_last   = (r_count == CNT_W'(XLEN-1));

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            MD_IDLE: if (w_accept) w_next_state = w_special ? MD_DONE : MD_ITER;
            MD_ITER: if (w_last)   w_next_state = MD_FIX;
            MD_FIX:                w_next_state = MD_DONE;
            MD_DONE:               w_next_state = MD_IDLE;
            default:               w_next_state = MD_IDLE;
        endcase
        if (bus.kill) w_next_state = MD_IDLE;
    end

    muldiv_sequencer_iter_datapath #(.XLEN(XLEN)) u_datapath (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_is_div   (r_op[2]),
        .i_opnd_a   (w_mag_a),
        .i_opnd_b   (w_mag_b),
        .o_product  (w_product),
        .o_quotient (w_quotient),
        .o_remainder(w_remainder)
    );

    assign w_prod_fix = (r_sign_a ^ r_sign_b) ? (~w_product + 1'b1) : w_product;
    assign w_quot_fix = (r_sign_a ^ r_sign_b) ? (~w_quotient + 1'b1) : w_quotient;
    assign w_rem_fix  = r_sign_a ? (~w_remainder + 1'b1) : w_remainder;

    always_comb begin
        w_fix_result = '0;
        if (r_op[2])
            w_fix_result = r_op[1] ? w_rem_fix : w_quot_fix;
        else if (r_op[1:0] == 2'b00)
            w_fix_result = w_prod_fix[XLEN-1:0];
        else
            w_fix_result = w_prod_fix[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= MD_IDLE;
            r_op           <= '0;
            r_sign_a       <= 1'b0;
            r_sign_b       <= 1'b0;
            r_count        <= '0;
            r_result       <= '0;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_busy         <= (w_next_state == MD_ITER) || (w_next_state == MD_FIX);
            r_result_valid <= (w_next_state == MD_DONE);
            if (w_accept) begin
                r_op     <= bus.op;
                r_sign_a <= w_sign_a;
                r_sign_b <= w_sign_b;
                r_count  <= '0;
            end else if (w_step) begin
                r_count  <= r_count + 1'b1;
            end
            if (w_accept && w_special)
                r_result <= w_special_result;
            else if (r_state == MD_FIX && !bus.kill)
                r_result <= w_fix_result;
        end
    end

    assign bus.stall        = !reset && ((r_state == MD_IDLE && bus.start && !bus.kill) ||
                                         r_state == MD_ITER || r_state == MD_FIX);
    assign bus.busy         = r_busy;
    assign bus.result_valid = r_result_valid;
    assign bus.result       = r_result;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - scoreboard bench for the iterative mul/div sequencer
module tb_muldiv_sequencer;
    import muldiv_sequencer_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    logic [31:0] exp_q[$];

    muldiv_sequencer_if #(.XLEN(32)) bus ();

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      pa_s, pb_s, pb_u;
        logic [63:0] p_ss, p_su, p_uu;
        int          sa, sb;
        sa   = a;
        sb   = b;
        pa_s = longint'(sa);
        pb_s = longint'(sb);
        pb_u = longint'({32'b0, b});
        p_ss = pa_s * pb_s;
        p_su = pa_s * pb_u;
        p_uu = {32'b0, a} * {32'b0, b};
        case (op)
            OP_MUL:    return p_ss[31:0];
            OP_MULH:   return p_ss[63:32];
            OP_MULHSU: return p_su[63:32];
            OP_MULHU:  return p_uu[63:32];
            OP_DIV: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            OP_REM: begin
                if (b == 32'h0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
            OP_DIVU:   return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            OP_REMU:   return (b == 32'h0) ? a : a % b;
            default:   return 32'h0;
        endcase
    endfunction

    task automatic idle();
        @(negedge clk);
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        reset     = 1'b0;
    endtask

    // Drives one operation starting at the next negedge (cycle 0) and follows it to its result.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input string name);
        bit          seen;
        bit          tbad;
        int          vcyc;
        logic [31:0] exp_v;
        exp_q.push_back(model(op, a, b));
        @(negedge clk);
        reset     = 1'b0;
        bus.kill  = 1'b0;
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        #1;
        checks++;
        if (bus.stall !== 1'b1 || bus.busy !== 1'b0 || bus.result_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_accept stall=%b busy=%b valid=%b required stall=1 busy=0 valid=0",
                     name, bus.stall, bus.busy, bus.result_valid);
        end
        seen = 1'b0;
        tbad = 1'b0;
        vcyc = 0;
        for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
            @(negedge clk);
            #1;
            if (bus.stall !== (cyc < lat)) tbad = 1'b1;
            if (bus.busy !== (lat > 1 && cyc < lat)) tbad = 1'b1;
            if (bus.result_valid !== (cyc == lat)) tbad = 1'b1;
            if (bus.result_valid === 1'b1) begin
                seen = 1'b1;
                vcyc = cyc;
            end
        end
        checks++;
        if (tbad || vcyc != lat) begin
            failures++;
            $display("FAIL %s_timing valid_cycle=%0d required=%0d handshake_mismatch=%0d", name, vcyc, lat, tbad);
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_timeout no result_valid within 40 cycles, required one at cycle %0d", name, lat);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s_result got=%h with empty scoreboard", name, bus.result);
        end else begin
            exp_v = exp_q.pop_front();
            if (bus.result !== exp_v) begin
                failures++;
                $display("FAIL %s_result got=%h required=%h", name, bus.result, exp_v);
            end
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.kill  = 1'b0;
        bus.op    = OP_MUL;
        bus.src_a = 32'd7;
        bus.src_b = 32'd3;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_stall got=%b required=0", bus.stall);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b required=0", bus.busy);
        end
        checks++;
        if (bus.result_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b required=0", bus.result_valid);
        end
        checks++;
        if (bus.result !== 32'h0) begin
            failures++;
            $display("FAIL reset_result got=%h required=00000000", bus.result);
        end
        idle();
    endtask

    task automatic test_mul_basic();
        run_op(OP_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 34, "mul_basic");
        idle();
    endtask

    task automatic test_mul_high();
        run_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "mulhu"); idle();
        run_op(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "mulh");  idle();
        run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "mulhsu"); idle();
        run_op(OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "mul_m1"); idle();
    endtask

    task automatic test_div();
        run_op(OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 34, "div");  idle();
        run_op(OP_REM,  32'hFFFF_FFF9, 32'h0000_0002, 34, "rem");  idle();
        run_op(OP_DIVU, 32'hFFFF_FFF9, 32'h0000_0002, 34, "divu"); idle();
        run_op(OP_REMU, 32'hFFFF_FFF9, 32'h0000_0002, 34, "remu"); idle();
    endtask

    task automatic test_fast_path();
        run_op(OP_DIV,  32'd5, 32'd0, 1, "div_by0");  idle();
        run_op(OP_REM,  32'd5, 32'd0, 1, "rem_by0");  idle();
        run_op(OP_REMU, 32'd5, 32'd0, 1, "remu_by0"); idle();
        run_op(OP_DIVU, 32'd5, 32'd0, 1, "divu_by0"); idle();
        run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1, "div_ovf"); idle();
        run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1, "rem_ovf"); idle();
    endtask

    task automatic test_kill(input bit use_reset);
        @(negedge clk);
        reset     = 1'b0;
        bus.kill  = 1'b0;
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.src_a = 32'hFFFF_FFF9;
        bus.src_b = 32'h0000_0002;
        for (int c = 1; c <= 10; c++) @(negedge clk);
        if (use_reset) reset = 1'b1;
        else           bus.kill = 1'b1;
        #1;
        checks++;
        if (use_reset) begin
            if (bus.stall !== 1'b0) begin
                failures++;
                $display("FAIL abort_reset_stall got=%b required=0", bus.stall);
            end
        end else if (bus.busy !== 1'b1 || bus.stall !== 1'b1) begin
            failures++;
            $display("FAIL abort_kill_iter busy=%b stall=%b required busy=1 stall=1", bus.busy, bus.stall);
        end
        run_op(OP_DIVU, 32'd100, 32'd7, 34, use_reset ? "divu_after_reset" : "divu_after_kill");
        idle();
    endtask

    task automatic test_kill_priority();
        @(negedge clk);
        bus.start = 1'b1;
        bus.kill  = 1'b1;
        bus.op    = OP_MUL;
        bus.src_a = 32'd3;
        bus.src_b = 32'd4;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL kill_prio_stall got=%b required=0", bus.stall);
        end
        idle();
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0) begin
            failures++;
            $display("FAIL kill_prio_state busy=%b valid=%b required busy=0 valid=0", bus.busy, bus.result_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  op;
        logic [31:0] a, b;
        int          lat;
        run_op(OP_MUL, 32'd12345, 32'd678, 34, "b2b_mul");
        run_op(OP_DIV, 32'hFFFF_FC18, 32'd7, 34, "b2b_div");
        for (int i = 0; i < 6; i++) begin
            op  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = (i == 2) ? 32'h0 : $urandom;
            lat = (op[2] && (b == 32'h0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 34;
            run_op(op, a, b, lat, "b2b_rand");
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_mul_high();
        test_div();
        test_fast_path();
        test_kill(1'b0);
        test_kill(1'b1);
        test_kill_priority();
        test_back_to_back();
        repeat (2) idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete within 500000 time units");
        $fatal(1, "watchdog expired");
    end
endmodule
